// File: rtl/apb_rr_arb_pkg.sv
// Shared types for the round-robin APB master arbiter: FSM states, the
// register bundle and its reset value.
package apb_rr_arb_pkg;

    localparam int PTR_W  = 3;   // enough for up to 8 requesters
    localparam int WDOG_W = 32;  // storage for the watchdog; live width set by TIMEOUT_BITS

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        state_e             state;
        logic [PTR_W-1:0]   ptr;
        logic [PTR_W-1:0]   owner;
        logic [31:0]        paddr;
        logic               pwrite;
        logic [31:0]        pwdata;
        logic [3:0]         pstrb;
        logic [31:0]        rdata;
        logic               err;
        logic [WDOG_W-1:0]  wdog;
    } apb_rr_arb_registers;

    localparam apb_rr_arb_registers apb_rr_arb_r_reset = '{
        state:  ST_IDLE,
        ptr:    '0,
        owner:  '0,
        paddr:  '0,
        pwrite: 1'b0,
        pwdata: '0,
        pstrb:  '0,
        rdata:  '0,
        err:    1'b0,
        wdog:   '0
    };

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin pick: first asserted request strictly after ptr,
// wrapping modulo NREQ, returned as one-hot plus index.
module rr_arbiter_onehot
    import apb_rr_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        // Offset 1..NREQ so ptr itself is checked last; the inner loop keeps
        // every vector index a constant.
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req_i[j] && (j == (int'(ptr_i) + i) % NREQ)) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = PTR_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin sharing of one APB master port between NREQ request/response
// initiators, with a pready watchdog so a dead slave cannot hang the bus.
module apb_rr_master_arbiter
    import apb_rr_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int TIMEOUT_BITS = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ*32-1:0] i_req_addr,
    input  logic [NREQ-1:0]   i_req_write,
    input  logic [NREQ*32-1:0] i_req_wdata,
    input  logic [NREQ*4-1:0] i_req_wstrb,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [NREQ-1:0]   o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err,
    output logic [31:0]       o_paddr,
    output logic              o_pwrite,
    output logic [31:0]       o_pwdata,
    output logic [3:0]        o_pstrb,
    output logic [2:0]        o_pprot,
    output logic              o_pselx,
    output logic              o_penable,
    input  logic [31:0]       i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);

    apb_rr_arb_registers r_q, r_d;

    logic [NREQ-1:0]  gnt;
    logic [PTR_W-1:0] gnt_idx;
    logic             timeout_hit;
    logic [31:0]      sel_addr, sel_wdata;
    logic             sel_write;
    logic [3:0]       sel_wstrb;

    rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
        .req_i (i_req_valid),
        .ptr_i (r_q.ptr),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Counter is 0 on the first ACCESS cycle, so TIMEOUT-1 marks the last allowed one.
    assign timeout_hit = (TIMEOUT != 0) &&
                         (r_q.wdog == WDOG_W'(TIMEOUT_BITS'(TIMEOUT - 1)));

    always_comb begin : comb_proc
        r_d          = r_q;
        o_req_ready  = '0;
        o_resp_valid = '0;
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_write    = 1'b0;
        sel_wstrb    = '0;

        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_addr  = i_req_addr[k*32 +: 32];
                sel_wdata = i_req_wdata[k*32 +: 32];
                sel_write = i_req_write[k];
                sel_wstrb = i_req_wstrb[k*4 +: 4];
            end
        end

        case (r_q.state)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    o_req_ready = gnt;
                    r_d.ptr     = gnt_idx;
                    r_d.owner   = gnt_idx;
                    r_d.paddr   = sel_addr & ~32'h3;
                    r_d.pwrite  = sel_write;
                    r_d.pwdata  = sel_wdata;
                    r_d.pstrb   = sel_wstrb;
                    r_d.state   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                r_d.wdog  = '0;
                r_d.state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (i_pready) begin
                    r_d.rdata = r_q.pwrite ? 32'h0 : i_prdata;
                    r_d.err   = i_pslverr;
                    r_d.wdog  = '0;
                    r_d.state = ST_RESP;
                end else if (timeout_hit) begin
                    r_d.rdata = 32'hFFFF_FFFF;
                    r_d.err   = 1'b1;
                    r_d.wdog  = '0;
                    r_d.state = ST_RESP;
                end else begin
                    r_d.wdog  = r_q.wdog + WDOG_W'(1);
                end
            end
            ST_RESP: begin
                for (int k = 0; k < NREQ; k++)
                    o_resp_valid[k] = (r_q.owner == PTR_W'(k));
                r_d.state = ST_IDLE;
            end
            default: r_d.state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_q <= apb_rr_arb_r_reset;
        else       r_q <= r_d;
    end

    assign o_pselx      = (r_q.state == ST_SETUP) || (r_q.state == ST_ACCESS);
    assign o_penable    = (r_q.state == ST_ACCESS);
    assign o_paddr      = r_q.paddr;
    assign o_pwrite     = r_q.pwrite;
    assign o_pwdata     = r_q.pwdata;
    assign o_pstrb      = r_q.pstrb;
    assign o_pprot      = 3'b000;
    assign o_resp_rdata = r_q.rdata;
    assign o_resp_err   = r_q.err;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level model of the arbiter.
module tb_apb_rr_master_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid, req_write;
    logic [NREQ*32-1:0] req_addr, req_wdata;
    logic [NREQ*4-1:0]  req_wstrb;
    logic [NREQ-1:0]    req_ready, resp_valid;
    logic [31:0]        resp_rdata, paddr, pwdata, prdata;
    logic               resp_err, pwrite, pselx, penable, pready, pslverr;
    logic [3:0]         pstrb;
    logic [2:0]         pprot;

    always #5 clk = ~clk;

    apb_rr_master_arbiter #(.NREQ(NREQ), .TIMEOUT_BITS(8), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_write(req_write),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_req_ready(req_ready), .o_resp_valid(resp_valid),
        .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_paddr(paddr), .o_pwrite(pwrite), .o_pwdata(pwdata), .o_pstrb(pstrb),
        .o_pprot(pprot), .o_pselx(pselx), .o_penable(penable),
        .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // model: m_age = cycles since the accepted handshake, -1 when no transaction
    int          m_age = -1;
    bit          m_resp = 0;
    int          m_last = 0;
    int          m_owner = 0;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] m_hold = 32'h0;
    logic        m_write, m_err;
    logic [3:0]  m_wstrb;

    // stimulus controls
    bit          rand_req = 0, keep_valid = 0;
    int          sl_force_wait = -1, sl_force_err = -1;
    bit          sl_force_data = 0;
    logic [31:0] sl_data = 32'h0;
    int          sl_cnt = 0, sl_wait = 0;
    bit          hs_prev = 0;
    int          hs_owner = 0;
    int          gq[$];
    bit          p_set[NREQ];
    logic [31:0] p_addr[NREQ], p_wdata[NREQ];
    logic        p_write[NREQ];
    logic [3:0]  p_wstrb[NREQ];
    bit          p_clr = 0;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int i = 1; i <= NREQ; i++)
            if (v[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
        p_set[k] = 1; p_addr[k] = a; p_write[k] = w; p_wdata[k] = d; p_wstrb[k] = s;
    endtask

    task automatic drive_req(input int k, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] s);
        req_addr[k*32 +: 32]  = a;
        req_write[k]          = w;
        req_wdata[k*32 +: 32] = d;
        req_wstrb[k*4 +: 4]   = s;
        req_valid[k]          = 1'b1;
    endtask

    task automatic model_reset();
        m_age = -1; m_resp = 0; m_last = 0; m_hold = 32'h0; hs_prev = 0;
    endtask

    task automatic step();
        int g, obs;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        if (penable) begin
            pready  = (sl_cnt == sl_wait);
            prdata  = sl_force_data ? sl_data : $urandom;
            pslverr = (sl_force_err >= 0) ? sl_force_err[0] : ($urandom_range(0, 3) == 0);
            sl_cnt++;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            sl_cnt  = 0;
            if (sl_force_wait >= 0) sl_wait = sl_force_wait;
            else if ($urandom_range(0, 4) == 0) sl_wait = int'($urandom_range(5, 12));
            else sl_wait = int'($urandom_range(0, 2));
        end
        if (hs_prev && !keep_valid) req_valid[hs_owner] = 1'b0;
        if (p_clr) begin req_valid = '0; p_clr = 0; end
        for (int k = 0; k < NREQ; k++) begin
            if (p_set[k]) begin
                drive_req(k, p_addr[k], p_write[k], p_wdata[k], p_wstrb[k]);
                p_set[k] = 0;
            end else if (rand_req && !(hs_prev && k == hs_owner)) begin
                if (!req_valid[k]) begin
                    if ($urandom_range(0, 3) == 0)
                        drive_req(k, $urandom, 1'($urandom), $urandom, 4'($urandom));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
        end
        hs_prev = 0;
        #1;
        exp_rdy = '0;
        if (m_age < 0) begin
            g = rr_pick(req_valid, m_last);
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("ready", 32'(req_ready), 32'(exp_rdy));
            chk("idle_apb", {30'b0, pselx, penable}, 32'h0);
            chk("idle_rv", 32'(resp_valid), 32'h0);
            chk("rdata_hold", resp_rdata, m_hold);
            if (req_ready != '0) begin
                obs = 0;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) obs = k;
                gq.push_back(obs);
            end
            if (g >= 0) begin
                m_age = 0; m_owner = g; m_last = g;
                m_addr  = req_addr[g*32 +: 32] & ~32'h3;
                m_write = req_write[g];
                m_wdata = req_wdata[g*32 +: 32];
                m_wstrb = req_wstrb[g*4 +: 4];
                hs_prev = 1; hs_owner = g;
            end
        end else if (m_resp) begin
            chk("resp_rv", 32'(resp_valid), 32'(1) << m_owner);
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_err", 32'(resp_err), 32'(m_err));
            chk("resp_apb", {30'b0, pselx, penable}, 32'h0);
            chk("resp_ready", 32'(req_ready), 32'h0);
            m_hold = m_rdata; m_resp = 0; m_age = -1;
        end else begin
            m_age++;
            chk("busy_ready", 32'(req_ready), 32'h0);
            chk("busy_apb", {30'b0, pselx, penable}, {30'b0, 1'b1, (m_age >= 2)});
            chk("paddr", paddr, m_addr);
            chk("pwrite", 32'(pwrite), 32'(m_write));
            chk("pwdata", pwdata, m_wdata);
            chk("pstrb", 32'(pstrb), 32'(m_wstrb));
            chk("pprot", 32'(pprot), 32'h0);
            chk("busy_rv", 32'(resp_valid), 32'h0);
            if (m_age >= 2) begin
                if (pready) begin
                    m_resp = 1; m_rdata = m_write ? 32'h0 : prdata; m_err = pslverr;
                end else if (TMO != 0 && m_age - 1 == TMO) begin
                    m_resp = 1; m_rdata = 32'hFFFF_FFFF; m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int pen_cnt, exp_order[5];
        logic [31:0] cap_rdata;
        logic        cap_err;
        bit          seen;
        exp_order = '{1, 2, 3, 0, 1};
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_apb", {30'b0, pselx, penable}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_wr", {pwdata[27:0], pstrb}, 32'h0);
        chk("rst_resp", {resp_rdata[30:0], resp_err}, 32'h0);
        chk("rst_rv_rdy", {24'b0, resp_valid, req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // single read, zero wait states
        sl_force_wait = 0; sl_force_err = 0; sl_force_data = 1; sl_data = 32'hCAFEF00D;
        set_req(0, 32'h1000, 1'b0, 32'h0, 4'hF);
        repeat (4) step();
        chk("t1_rv", 32'(resp_valid), 32'h1);
        chk("t1_rdata", resp_rdata, 32'hCAFEF00D);
        chk("t1_err", 32'(resp_err), 32'h0);
        repeat (2) step();

        // contention from ptr 0
        do_reset();
        sl_force_data = 0; keep_valid = 1; gq.delete();
        for (int k = 0; k < NREQ; k++) set_req(k, 32'(k * 16), 1'b0, 32'h0, 4'hF);
        repeat (20) step();
        for (int i = 0; i < 5; i++)
            chk("rr_order", (gq.size() > i) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        keep_valid = 0; p_clr = 1;
        repeat (6) step();

        // wait states then slave error
        sl_force_wait = 5; sl_force_err = 1; pen_cnt = 0; cap_err = 1'b0;
        set_req(1, 32'h2000, 1'b0, 32'h0, 4'hF);
        repeat (12) begin
            step();
            if (penable) pen_cnt++;
            if (resp_valid != '0) cap_err = resp_err;
        end
        chk("t3_pen_cycles", 32'(pen_cnt), 32'd6);
        chk("t3_err", 32'(cap_err), 32'h1);

        // watchdog timeout, then a normal transaction
        sl_force_wait = 100; sl_force_err = 0; pen_cnt = 0; cap_rdata = 32'h0; cap_err = 1'b0;
        set_req(3, 32'h3000, 1'b0, 32'h0, 4'hF);
        repeat (14) begin
            step();
            if (penable) pen_cnt++;
            if (resp_valid != '0) begin cap_rdata = resp_rdata; cap_err = resp_err; end
        end
        chk("t4_pen_cycles", 32'(pen_cnt), 32'd8);
        chk("t4_rdata", cap_rdata, 32'hFFFF_FFFF);
        chk("t4_err", 32'(cap_err), 32'h1);
        sl_force_wait = 0; cap_err = 1'b1;
        set_req(3, 32'h3004, 1'b0, 32'h0, 4'hF);
        repeat (6) begin
            step();
            if (resp_valid != '0) cap_err = resp_err;
        end
        chk("t4_next_err", 32'(cap_err), 32'h0);

        // reset while penable is high
        sl_force_wait = 100; seen = 0;
        set_req(2, 32'h4000, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = penable;
        end
        chk("t5_reached_access", 32'(seen), 32'h1);
        rst = 1'b1;
        #1;
        chk("t5_apb_drop", {30'b0, pselx, penable}, 32'h0);
        chk("t5_rv", 32'(resp_valid), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sl_force_wait = 0; gq.delete();
        set_req(1, 32'h5000, 1'b0, 32'h0, 4'hF);
        set_req(3, 32'h5004, 1'b0, 32'h0, 4'hF);
        repeat (10) step();
        chk("t5_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF_FFFF, 32'd1);

        // write through requester 2
        set_req(2, 32'h6000, 1'b1, 32'h12345678, 4'b0011);
        step();
        step();
        chk("t6_setup", {pwdata[27:0], pstrb}, {28'h2345678, 4'b0011});
        chk("t6_setup_wr", {30'b0, pwrite, penable}, 32'h2);
        step();
        chk("t6_access", {pwdata[27:0], pstrb}, {28'h2345678, 4'b0011});
        chk("t6_access_wr", {30'b0, pwrite, penable}, 32'h3);
        step();
        chk("t6_rdata", resp_rdata, 32'h0);
        chk("t6_rv", 32'(resp_valid), 32'h4);

        // random traffic
        sl_force_wait = -1; sl_force_err = -1; sl_force_data = 0; rand_req = 1;
        repeat (4000) step();
        rand_req = 0; p_clr = 1;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

endmodule
